sprite_compositor: RTL
======================

# sprite_compositor

Parametrised multi-sprite pixel compositor between the VGA controller's DrawX/DrawY and the VGA DAC outputs. It overlays up to NUM_SPRITES monochrome sprites, each with its own colour, plus a text layer, on a background pixel stream. Sprite state is written through a handshake into shadow registers and copied to active registers at each frame boundary, so positions never change mid-frame. A per-sprite collision flag is captured every frame.

## Interface
- NUM_SPRITES, 4, number of sprite channels (1–8)
- SPRITE_W, 32, sprite width in pixels; equals the ROM data width
- SPRITE_H, 32, sprite height in rows
- COORD_W, 10, width of pixel coordinates
- ROM_ADDR_W, 7, sprite ROM row-address width
- Clk  in  1  pixel clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when high with cfg_valid
- cfg_idx  in  $clog2(NUM_SPRITES)  target sprite
- cfg_x, cfg_y  in  COORD_W each  sprite top-left
- cfg_row_base  in  ROM_ADDR_W  first ROM row of the sprite image
- cfg_color  in  24  {R,G,B} sprite colour
- cfg_enable, cfg_flip  in  1 each  sprite visible; horizontal mirror
- pix_valid  in  1  DrawX/DrawY/bg/text inputs valid this cycle
- DrawX, DrawY  in  COORD_W each  current pixel
- bg_r, bg_g, bg_b  in  8 each  background colour
- text_on  in  1  text layer pixel set (font bit already resolved)
- rom_addr  out  NUM_SPRITES×ROM_ADDR_W  per-channel ROM row address
- rom_data  in  NUM_SPRITES×SPRITE_W  per-channel ROM row, one-cycle registered read
- out_valid  out  1  VGA_R/G/B valid
- VGA_R, VGA_G, VGA_B  out  8 each  composited colour
- collision  out  NUM_SPRITES  sprite overlapped another opaque sprite last frame

## Operation
- Config: write accepted on cycle with cfg_valid && cfg_ready; stored in shadow[cfg_idx]. cfg_ready = 0 during the frame_start cycle, 1 otherwise (after reset).
- frame_start: every shadow entry copied to active in that cycle; collision output loaded from sticky flags; sticky flags cleared.
- Hit test per channel, on active regs: DrawX ≥ x and (DrawX − x) < SPRITE_W, same for Y with SPRITE_H, computed in COORD_W+1 bits unsigned (no wrap at right/bottom edge); requires enable.
- rom_addr = row_base + (DrawY − y), truncated to ROM_ADDR_W (modular wrap). Non-hit channels drive rom_addr = 0.
- Column col = DrawX − x; opaque = rom_data[col] (flip: rom_data[SPRITE_W−1−col]).
- Priority: text_on → 0xFFFFFF; else lowest-index opaque sprite → its cfg_color; else bg.
- Collision: if ≥2 channels opaque on one valid pixel, each of them sets its sticky flag.
- Reset: active/shadow regs 0 (all disabled), sticky flags 0, collision 0, out_valid 0, VGA_R/G/B 0, cfg_ready 1, rom_addr 0.

## Timing
- Stage 0 (pix_valid cycle): hit test, rom_addr registered with hit, col, bg, text_on.
- Stage 1: rom_data valid; opacity, priority, collision; result registered.
- out_valid and VGA_R/G/B appear exactly 2 cycles after pix_valid; pix_valid low → out_valid low 2 cycles later, VGA values held.
- Fully pipelined, one pixel per cycle, no stalls.
- cfg write and frame_start same cycle: write not accepted (cfg_ready low); master retries.
- Config accepted in cycle N visible on active regs only after next frame_start.
- Pixels in flight at frame_start use the registers sampled at their stage 0.
- Reset mid-operation clears the pipeline instantly; in-flight pixels discarded.

## Configuration
- SPRITE_MIRROR_EN: defined → cfg_flip stored and applied as above. Undefined → cfg_flip port remains but is ignored, no flip storage or mux; column always rom_data[col].

## Structure
- compositor_pkg: rgb_t (8-bit r/g/b struct), sprite_cfg_t (x, y, row_base, color, enable, flip), COLOR_WHITE constant.
- Sub-module sprite_channel (one per sprite, generate loop): active/shadow regs, hit test, rom_addr, stage-1 opacity bit.

## Test plan
- Reset, then pix_valid with bg=0x102030, no sprites → VGA = 0x102030 exactly 2 cycles later; collision = 0.
- Write sprite0 x=100,y=50,row_base=64,color=0xFF0000,enable; frame_start; DrawX=100,DrawY=50 → rom_addr[0]=64; rom_data bit0=1 → VGA=0xFF0000; DrawX=132 → bg.
- Sprite0 and sprite1 both opaque at (200,200) → sprite0 colour wins; after next frame_start collision=0b0011.
- text_on=1 over opaque sprite → VGA=0xFFFFFF.
- cfg_valid held across frame_start cycle → cfg_ready=0 that cycle, write accepted next cycle, takes effect only after following frame_start.
- SPRITE_MIRROR_EN with flip=1, x=0, DrawX=0 → uses rom_data[31]; without macro → rom_data[0].

Source files
------------

// File: rtl/compositor_pkg.sv
// Shared types for the sprite compositor: colour triple, per-sprite configuration word, white constant.
// Configuration fields are sized for the widest supported coordinate / ROM address (16 bits).
package compositor_pkg;

    localparam int CFG_COORD_W = 16;
    localparam int CFG_ADDR_W  = 16;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic [CFG_COORD_W-1:0] x;
        logic [CFG_COORD_W-1:0] y;
        logic [CFG_ADDR_W-1:0]  row_base;
        rgb_t                   color;
        logic                   enable;
        logic                   flip;
    } sprite_cfg_t;

    localparam rgb_t COLOR_WHITE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: shadow/active config, hit test, ROM row address and stage-1 opacity bit.
// Optional horizontal mirroring is compiled in with SPRITE_MIRROR_EN.
module sprite_channel
    import compositor_pkg::*;
#(
    parameter int SPRITE_W   = 32,
    parameter int SPRITE_H   = 32,
    parameter int COORD_W    = 10,
    parameter int ROM_ADDR_W = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  cfg_we,
    input  sprite_cfg_t           cfg,
    input  logic                  pix_valid,
    input  logic [COORD_W-1:0]    draw_x,
    input  logic [COORD_W-1:0]    draw_y,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [SPRITE_W-1:0]   rom_data,
    output logic                  opaque,
    output rgb_t                  color_p0
);

    localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int EXT_W = CFG_COORD_W + 1;

    sprite_cfg_t shadow;
    sprite_cfg_t active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (cfg_we)
                shadow <= cfg;
            if (frame_start)
                active <= shadow;
        end
    end

    // Offsets are taken one bit wider than the coordinates so a sprite never wraps past the edge.
    logic [EXT_W-1:0] px, py, sx, sy, dx, dy;
    logic             hit;

    always_comb begin
        px  = EXT_W'(draw_x);
        py  = EXT_W'(draw_y);
        sx  = {1'b0, active.x};
        sy  = {1'b0, active.y};
        dx  = px - sx;
        dy  = py - sy;
        hit = pix_valid && active.enable
              && (px >= sx) && (dx < EXT_W'(SPRITE_W))
              && (py >= sy) && (dy < EXT_W'(SPRITE_H));
    end

    // ---- stage 0 -> stage 1 boundary ----
    logic [ROM_ADDR_W-1:0] rom_addr_p0;
    logic                  hit_p0;
    logic [COL_W-1:0]      col_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_p0      <= 1'b0;
            rom_addr_p0 <= '0;
        end else begin
            hit_p0      <= hit;
            rom_addr_p0 <= hit ? ROM_ADDR_W'({1'b0, active.row_base} + dy) : '0;
        end
    end

    always_ff @(posedge clk) begin
        col_p0   <= COL_W'(dx);
        color_p0 <= active.color;
    end

    assign rom_addr = rom_addr_p0;

`ifdef SPRITE_MIRROR_EN
    logic             flip_p0;
    logic [COL_W-1:0] bit_sel;

    always_ff @(posedge clk) begin
        flip_p0 <= active.flip;
    end

    always_comb begin
        bit_sel = flip_p0 ? (COL_W'(SPRITE_W - 1) - col_p0) : col_p0;
        opaque  = hit_p0 && rom_data[bit_sel];
    end
`else
    logic unused_flip;
    assign unused_flip = active.flip;

    always_comb begin
        opaque = hit_p0 && rom_data[col_p0];
    end
`endif

endmodule

// File: rtl/sprite_compositor.sv
// Multi-sprite pixel compositor: text > lowest-index opaque sprite > background, 2-cycle latency.
// Define SPRITE_MIRROR_EN to honour cfg_flip (horizontal mirror); otherwise cfg_flip is ignored.
module sprite_compositor
    import compositor_pkg::*;
#(
    parameter  int NUM_SPRITES = 4,
    parameter  int SPRITE_W    = 32,
    parameter  int SPRITE_H    = 32,
    parameter  int COORD_W     = 10,
    parameter  int ROM_ADDR_W  = 7,
    localparam int IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                             Clk,
    input  logic                             Reset_n,
    input  logic                             frame_start,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic [IDX_W-1:0]                 cfg_idx,
    input  logic [COORD_W-1:0]               cfg_x,
    input  logic [COORD_W-1:0]               cfg_y,
    input  logic [ROM_ADDR_W-1:0]            cfg_row_base,
    input  logic [23:0]                      cfg_color,
    input  logic                             cfg_enable,
    input  logic                             cfg_flip,
    input  logic                             pix_valid,
    input  logic [COORD_W-1:0]               DrawX,
    input  logic [COORD_W-1:0]               DrawY,
    input  logic [7:0]                       bg_r,
    input  logic [7:0]                       bg_g,
    input  logic [7:0]                       bg_b,
    input  logic                             text_on,
    output logic [NUM_SPRITES*ROM_ADDR_W-1:0] rom_addr,
    input  logic [NUM_SPRITES*SPRITE_W-1:0]  rom_data,
    output logic                             out_valid,
    output logic [7:0]                       VGA_R,
    output logic [7:0]                       VGA_G,
    output logic [7:0]                       VGA_B,
    output logic [NUM_SPRITES-1:0]           collision
);

    // The frame_start cycle belongs to the shadow->active copy, so writes are held off.
    assign cfg_ready = !frame_start;

    logic        cfg_accept;
    sprite_cfg_t cfg_word;

    always_comb begin
        cfg_accept        = cfg_valid && cfg_ready;
        cfg_word          = '0;
        cfg_word.x        = CFG_COORD_W'(cfg_x);
        cfg_word.y        = CFG_COORD_W'(cfg_y);
        cfg_word.row_base = CFG_ADDR_W'(cfg_row_base);
        cfg_word.color    = rgb_t'(cfg_color);
        cfg_word.enable   = cfg_enable;
`ifdef SPRITE_MIRROR_EN
        cfg_word.flip     = cfg_flip;
`else
        cfg_word.flip     = 1'b0;
`endif
    end

`ifndef SPRITE_MIRROR_EN
    logic unused_cfg_flip;
    assign unused_cfg_flip = cfg_flip;
`endif

    logic [NUM_SPRITES-1:0] opaque;
    rgb_t                   color_p0 [NUM_SPRITES];

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_ch
        sprite_channel #(
            .SPRITE_W   (SPRITE_W),
            .SPRITE_H   (SPRITE_H),
            .COORD_W    (COORD_W),
            .ROM_ADDR_W (ROM_ADDR_W)
        ) u_ch (
            .clk         (Clk),
            .rst_n       (Reset_n),
            .frame_start (frame_start),
            .cfg_we      (cfg_accept && (cfg_idx == IDX_W'(i))),
            .cfg         (cfg_word),
            .pix_valid   (pix_valid),
            .draw_x      (DrawX),
            .draw_y      (DrawY),
            .rom_addr    (rom_addr[i*ROM_ADDR_W +: ROM_ADDR_W]),
            .rom_data    (rom_data[i*SPRITE_W +: SPRITE_W]),
            .opaque      (opaque[i]),
            .color_p0    (color_p0[i])
        );
    end

    // ---- stage 0 -> stage 1 boundary ----
    logic vld_p0;
    logic text_p0;
    rgb_t bg_p0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            vld_p0 <= 1'b0;
        else
            vld_p0 <= pix_valid;
    end

    always_ff @(posedge Clk) begin
        text_p0 <= text_on;
        bg_p0   <= '{r: bg_r, g: bg_g, b: bg_b};
    end

    rgb_t                   pick;
    logic                   multi;
    logic [NUM_SPRITES-1:0] coll_set;

    always_comb begin
        pick = bg_p0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (opaque[i])
                pick = color_p0[i];
        end
        if (text_p0)
            pick = COLOR_WHITE;
        // More than one bit set: clearing the lowest set bit leaves something behind.
        multi    = |(opaque & (opaque - NUM_SPRITES'(1)));
        coll_set = (vld_p0 && multi) ? opaque : '0;
    end

    // ---- stage 1 -> output boundary ----
    logic                   vld_p1;
    rgb_t                   rgb_p1;
    logic [NUM_SPRITES-1:0] sticky;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_p1    <= 1'b0;
            rgb_p1    <= '0;
            sticky    <= '0;
            collision <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0)
                rgb_p1 <= pick;
            if (frame_start) begin
                collision <= sticky;
                sticky    <= coll_set;
            end else begin
                sticky    <= sticky | coll_set;
            end
        end
    end

    assign out_valid = vld_p1;
    assign VGA_R     = rgb_p1.r;
    assign VGA_G     = rgb_p1.g;
    assign VGA_B     = rgb_p1.b;

endmodule
